// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and constants for the BTB update controller and its resolution FIFO.
package btb_update_ctrl_pkg;

    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic {
        BTBC_IDLE  = 1'b0,
        BTBC_SWEEP = 1'b1
    } btbc_state_t;

    // One queued branch resolution as written into the BTB.
    typedef struct packed {
        logic [31:0] pc;
        logic        jump;
        logic [31:0] addr;
    } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO for branch resolutions; head is read combinationally.
module btb_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clr) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// Sequences BTB writes: drains queued EX resolutions, flags mispredicts, runs invalidate sweeps.
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int BTB_ENTRIES = 32,
    parameter int IDX_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              branch_from_ex,
    input  logic [31:0]       pc_from_ex,
    input  logic              jump_from_ex,
    input  logic [31:0]       jump_addr_from_ex,
    input  logic              pred_from_ex,
    input  logic [31:0]       pred_addr_from_ex,
    input  logic              inv_all_req,
    output logic              upd_valid_to_btb,
    output logic [31:0]       upd_pc_to_btb,
    output logic              upd_jump_to_btb,
    output logic [31:0]       upd_addr_to_btb,
    output logic              inv_valid_to_btb,
    output logic [IDX_W-1:0]  inv_index_to_btb,
    output logic              flush_to_pipe,
    output logic [31:0]       redirect_pc_to_if,
    output logic              sweep_busy,
    output logic [7:0]        drop_cnt,
    output btbc_state_t       state_dbg
);
    localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(BTB_ENTRIES - 1);

    btbc_state_t      state;
    btbc_state_t      state_next;
    logic [IDX_W-1:0] sweep_idx;
    logic             upd_valid_q;
    btb_upd_t         upd_q;
    logic             flush_q;
    logic [31:0]      redirect_q;
    logic [7:0]       drop_cnt_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clr;
    logic             fifo_full;
    logic             fifo_empty;
    btb_upd_t         fifo_head;
    btb_upd_t         new_entry;
    logic             drop_evt;
    logic             mis;
    logic [31:0]      redirect_next;

    assign new_entry     = '{pc: pc_from_ex, jump: jump_from_ex, addr: jump_addr_from_ex};
    assign mis           = (pred_from_ex != jump_from_ex) ||
                           (pred_from_ex && jump_from_ex && (pred_addr_from_ex != jump_addr_from_ex));
    assign redirect_next = jump_from_ex ? jump_addr_from_ex : pc_from_ex + 32'd4;

    btb_upd_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(btb_upd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (new_entry),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst)      state <= BTBC_IDLE;
        else if (rdy) state <= state_next;
    end

    // A sweep request takes priority over both draining and the same-cycle push.
    always_comb begin
        state_next = state;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_clr   = 1'b0;
        drop_evt   = 1'b0;
        case (state)
            BTBC_IDLE: begin
                if (inv_all_req) begin
                    state_next = BTBC_SWEEP;
                    fifo_clr   = rdy;
                    drop_evt   = branch_from_ex;
                end else begin
                    fifo_pop  = rdy && !fifo_empty;
                    fifo_push = rdy && branch_from_ex;
                    drop_evt  = branch_from_ex && fifo_full && !fifo_pop;
                end
            end
            BTBC_SWEEP: begin
                drop_evt = branch_from_ex;
                if (sweep_idx == SWEEP_LAST) state_next = BTBC_IDLE;
            end
            default: state_next = BTBC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_idx   <= '0;
            upd_valid_q <= DISABLE;
            upd_q       <= '0;
            flush_q     <= DISABLE;
            redirect_q  <= ZERO_WORD;
            drop_cnt_q  <= '0;
        end else if (rdy) begin
            sweep_idx   <= (state == BTBC_SWEEP) ? sweep_idx + IDX_W'(1) : '0;
            upd_valid_q <= fifo_pop;
            if (fifo_pop) upd_q <= fifo_head;
            flush_q <= branch_from_ex && mis;
            if (branch_from_ex && mis) redirect_q <= redirect_next;
            if (drop_evt && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    // Strobes are masked while frozen so a held register never writes twice.
    assign upd_valid_to_btb  = upd_valid_q && rdy;
    assign upd_pc_to_btb     = upd_q.pc;
    assign upd_jump_to_btb   = upd_q.jump;
    assign upd_addr_to_btb   = upd_q.addr;
    assign inv_valid_to_btb  = (state == BTBC_SWEEP) && rdy;
    assign inv_index_to_btb  = sweep_idx;
    assign flush_to_pipe     = flush_q && rdy;
    assign redirect_pc_to_if = redirect_q;
    assign sweep_busy        = (state == BTBC_SWEEP);
    assign drop_cnt          = drop_cnt_q;
    assign state_dbg         = state;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: scoreboard queues for BTB updates and flushes.
module tb_btb_update_ctrl;
    import btb_update_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, branch_from_ex, jump_from_ex, pred_from_ex, inv_all_req;
    logic [31:0] pc_from_ex, jump_addr_from_ex, pred_addr_from_ex;
    logic        upd_valid_to_btb, upd_jump_to_btb, inv_valid_to_btb, flush_to_pipe, sweep_busy;
    logic [31:0] upd_pc_to_btb, upd_addr_to_btb, redirect_pc_to_if;
    logic [4:0]  inv_index_to_btb;
    logic [7:0]  drop_cnt;
    btbc_state_t state_dbg;

    logic [64:0] exp_q[$];
    logic [31:0] flush_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_drop = 0;
    int          inv_cnt  = 0;
    int          exp_idx  = 0;
    int          sweeps   = 0;

    btb_update_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .branch_from_ex(branch_from_ex), .pc_from_ex(pc_from_ex),
        .jump_from_ex(jump_from_ex), .jump_addr_from_ex(jump_addr_from_ex),
        .pred_from_ex(pred_from_ex), .pred_addr_from_ex(pred_addr_from_ex),
        .inv_all_req(inv_all_req),
        .upd_valid_to_btb(upd_valid_to_btb), .upd_pc_to_btb(upd_pc_to_btb),
        .upd_jump_to_btb(upd_jump_to_btb), .upd_addr_to_btb(upd_addr_to_btb),
        .inv_valid_to_btb(inv_valid_to_btb), .inv_index_to_btb(inv_index_to_btb),
        .flush_to_pipe(flush_to_pipe), .redirect_pc_to_if(redirect_pc_to_if),
        .sweep_busy(sweep_busy), .drop_cnt(drop_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = accepted into the BTB, 1 = queued then discarded by a sweep, 2 = dropped
    task automatic send_branch(input logic [31:0] pc, input logic jump, input logic [31:0] addr,
                               input logic pred, input logic [31:0] paddr, input int kind);
        logic mis;
        branch_from_ex    = 1'b1;
        pc_from_ex        = pc;
        jump_from_ex      = jump;
        jump_addr_from_ex = addr;
        pred_from_ex      = pred;
        pred_addr_from_ex = paddr;
        mis = (pred != jump) || (pred && jump && paddr != addr);
        if (mis) flush_q.push_back(jump ? addr : pc + 32'd4);
        if (kind == 0) exp_q.push_back({pc, jump, addr});
        if (kind == 2 && exp_drop < 255) exp_drop++;
        tick();
        branch_from_ex = 1'b0;
    endtask

    task automatic wait_sweep_done(input int max_cycles);
        int n = 0;
        while (sweep_busy && n < max_cycles) begin
            tick();
            n++;
        end
        if (sweep_busy) check("sweep_timeout", 1, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_upd"}, {upd_valid_to_btb, upd_pc_to_btb, upd_jump_to_btb, upd_addr_to_btb}, 0);
        check({tag, "_inv"}, {inv_valid_to_btb, inv_index_to_btb}, 0);
        check({tag, "_flush"}, {flush_to_pipe, redirect_pc_to_if}, 0);
        check({tag, "_busy_drop"}, {sweep_busy, drop_cnt}, 0);
        check({tag, "_state"}, state_dbg, BTBC_IDLE);
    endtask

    // Monitor: pops scoreboards on every visible strobe, tracks sweep index order.
    always @(negedge clk) begin
        if (rst) begin
            inv_cnt = 0;
            exp_idx = 0;
        end else begin
            if (!rdy) check("strobe_rdy0", {upd_valid_to_btb, inv_valid_to_btb, flush_to_pipe}, 0);
            if (upd_valid_to_btb && inv_valid_to_btb) check("upd_inv_both", 1, 0);
            if (upd_valid_to_btb) begin
                if (exp_q.size() == 0) check("upd_unexpected", 1, 0);
                else check("upd", {upd_pc_to_btb, upd_jump_to_btb, upd_addr_to_btb}, exp_q.pop_front());
            end
            if (flush_to_pipe) begin
                if (flush_q.size() == 0) check("flush_unexpected", 1, 0);
                else check("redirect", redirect_pc_to_if, flush_q.pop_front());
            end
            if (inv_valid_to_btb) begin
                check("inv_index", inv_index_to_btb, exp_idx[4:0]);
                exp_idx = (exp_idx + 1) % 32;
                inv_cnt++;
            end else if (inv_cnt != 0 && rdy) begin
                check("sweep_len", inv_cnt, 32);
                inv_cnt = 0;
                exp_idx = 0;
                sweeps++;
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; branch_from_ex = 1'b0; inv_all_req = 1'b0;
        pc_from_ex = '0; jump_from_ex = 1'b0; jump_addr_from_ex = '0;
        pred_from_ex = 1'b0; pred_addr_from_ex = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Mispredicted taken branch: flush next cycle, update the cycle after.
        send_branch(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 0);
        check("t1_flush", flush_to_pipe, 1);
        check("t1_redirect", redirect_pc_to_if, 32'h200);
        check("t1_upd_early", upd_valid_to_btb, 0);
        tick();
        check("t1_upd", {upd_valid_to_btb, upd_pc_to_btb, upd_jump_to_btb}, {1'b1, 32'h100, 1'b1});
        check("t1_flush_one", flush_to_pipe, 0);
        repeat (2) tick();

        // Correct prediction: no flush.
        send_branch(32'h140, 1'b1, 32'h200, 1'b1, 32'h200, 0);
        check("t2_noflush", flush_to_pipe, 0);
        repeat (3) tick();

        // Predicted taken, not taken at the top of memory: fall-through wraps to 0.
        send_branch(32'hFFFF_FFFC, 1'b0, 32'h500, 1'b1, 32'h500, 0);
        check("t3_flush", flush_to_pipe, 1);
        check("t3_redirect", redirect_pc_to_if, 32'h0);
        // Taken both ways but to a different target.
        send_branch(32'h180, 1'b1, 32'h700, 1'b1, 32'h600, 0);
        repeat (3) tick();

        // Six back-to-back resolutions with a three-cycle freeze in the middle.
        for (int i = 0; i < 6; i++) begin
            logic j, p;
            j = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            send_branch(32'h1000 + 32'(i * 4), j, 32'h8000 + 32'($urandom_range(0, 255) * 4),
                        p, 32'h8000, 0);
            if (i == 2) begin
                rdy = 1'b0;
                repeat (3) tick();
                rdy = 1'b1;
            end
        end
        repeat (4) tick();
        check("t4_drained", exp_q.size(), 0);
        check("t4_drop", drop_cnt, 0);

        // Sweep with a queued entry, a mid-sweep mispredict and an ignored re-request.
        send_branch(32'h2000, 1'b1, 32'h2100, 1'b1, 32'h2100, 0);
        send_branch(32'h2004, 1'b0, 32'h2200, 1'b0, 32'h2200, 0);
        send_branch(32'h2008, 1'b1, 32'h2300, 1'b1, 32'h2300, 1);
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        check("t5_busy", sweep_busy, 1);
        repeat (4) tick();
        send_branch(32'h300, 1'b1, 32'h400, 1'b0, 32'h0, 2);
        check("t5_flush", flush_to_pipe, 1);
        check("t5_drop", drop_cnt, 8'(exp_drop));
        repeat (3) tick();
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        wait_sweep_done(100);
        repeat (3) tick();
        check("t5_sweeps", sweeps, 1);
        check("t5_discarded", exp_q.size(), 0);

        // Reset while the sweep is at index 10.
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        for (int n = 0; n < 64 && inv_index_to_btb != 5'd10; n++) tick();
        check("t6_reached10", inv_index_to_btb, 5'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_drop = 0;
        check_all_zero("t6_midsweep_rst");

        // Continuous requests and branches: every branch dropped, counter saturates.
        inv_all_req = 1'b1;
        for (int n = 0; n < 300; n++) send_branch(32'h4000, 1'b0, 32'h0, 1'b0, 32'h0, 2);
        inv_all_req = 1'b0;
        wait_sweep_done(100);
        tick();
        check("t7_drop_sat", drop_cnt, 8'hFF);
        check("t7_no_upd", exp_q.size(), 0);
        check("t7_flush_left", flush_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
